// File: rtl/alu_operand_sequencer_pkg.sv
// Shared constants and enums for the ALU operand sequencer and its ALU.
// Operand/result width, opcode encoding and sequencer state encoding live here.
package alu_pkg;

  localparam int WIDTH = 6;
  localparam int OPW   = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_GT    = 3'd5,
    OP_PASSA = 3'd6,
    OP_PASSB = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_WAIT_A = 2'd0,
    S_WAIT_B = 2'd1,
    S_ISSUE  = 2'd2,
    S_DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Valid/ready operand bus between the sequencer (master) and the ALU (slave).
interface alu_operand_sequencer_if;
  import alu_pkg::*;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic             alu_valid;
  logic             alu_ready;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output alu_a, alu_b, alu_op, alu_valid,
    input  alu_ready, alu_result
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_valid,
    output alu_ready, alu_result
  );

endinterface

// File: rtl/alu_operand_sequencer_rise_edge_det.sv
// Single-cycle rising-edge pulse from an already synchronised button level.
// History resets high so a button held through reset never produces an edge.
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_din;
    end
  end

  assign o_pulse = i_din & ~r_prev;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures A, B and opcode from switches on load presses, issues them to the ALU
// under valid/ready, and registers the returned result with zero/negative flags.
module alu_operand_sequencer
  import alu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load_btn,
  input  logic                    i_clear_btn,
  input  logic [WIDTH-1:0]        i_sw_data,
  input  logic [OPW-1:0]          i_sw_op,
  alu_operand_sequencer_if.master alu_if,
  output logic [WIDTH-1:0]        o_res_q,
  output logic                    o_res_valid,
  output logic                    o_zero_flag,
  output logic                    o_neg_flag,
  output logic [1:0]              o_state_q
);

  logic w_load_edge;
  logic w_clear_edge;

  seq_state_t       r_state;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic             r_alu_valid;
  logic [WIDTH-1:0] r_res_q;
  logic             r_res_valid;
  logic             r_zero_flag;
  logic             r_neg_flag;

  rise_edge_det u_load_edge (
    .clk     (clk),
    .reset   (reset),
    .i_din   (i_load_btn),
    .o_pulse (w_load_edge)
  );

  rise_edge_det u_clear_edge (
    .clk     (clk),
    .reset   (reset),
    .i_din   (i_clear_btn),
    .o_pulse (w_clear_edge)
  );

  // Clear outranks load and the handshake, so an abort never lets a result land.
  always_ff @(posedge clk) begin
    if (reset || w_clear_edge) begin
      r_state     <= S_WAIT_A;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_valid <= 1'b0;
      r_res_q     <= '0;
      r_res_valid <= 1'b0;
      r_zero_flag <= 1'b0;
      r_neg_flag  <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_A: begin
          if (w_load_edge) begin
            r_alu_a <= i_sw_data;
            r_state <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (w_load_edge) begin
            r_alu_b     <= i_sw_data;
            r_alu_op    <= i_sw_op;
            r_alu_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_alu_valid && alu_if.alu_ready) begin
            r_res_q     <= alu_if.alu_result;
            r_zero_flag <= (alu_if.alu_result == '0);
            r_neg_flag  <= alu_if.alu_result[WIDTH-1];
            r_res_valid <= 1'b1;
            r_alu_valid <= 1'b0;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Old result and flags stay on the display until the next one arrives.
          if (w_load_edge) begin
            r_alu_a     <= i_sw_data;
            r_res_valid <= 1'b0;
            r_state     <= S_WAIT_B;
          end
        end
        default: r_state <= S_WAIT_A;
      endcase
    end
  end

  assign alu_if.alu_a     = r_alu_a;
  assign alu_if.alu_b     = r_alu_b;
  assign alu_if.alu_op    = r_alu_op;
  assign alu_if.alu_valid = r_alu_valid;

  assign o_res_q     = r_res_q;
  assign o_res_valid = r_res_valid;
  assign o_zero_flag = r_zero_flag;
  assign o_neg_flag  = r_neg_flag;
  assign o_state_q   = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: a press-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  logic             clk;
  logic             reset;
  logic             loadBtn;
  logic             clearBtn;
  logic [WIDTH-1:0] swData;
  logic [OPW-1:0]   swOp;
  logic [WIDTH-1:0] resQ;
  logic             resValid;
  logic             zeroFlag;
  logic             negFlag;
  logic [1:0]       stateQ;

  int assertCount;
  int failCount;

  alu_operand_sequencer_if aluIf ();

  alu_operand_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .i_load_btn  (loadBtn),
    .i_clear_btn (clearBtn),
    .i_sw_data   (swData),
    .i_sw_op     (swOp),
    .alu_if      (aluIf),
    .o_res_q     (resQ),
    .o_res_valid (resValid),
    .o_zero_flag (zeroFlag),
    .o_neg_flag  (negFlag),
    .o_state_q   (stateQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Press-level model: phase counts how far the operator has got through A, B, result.
  int             mPhase;
  logic [WIDTH-1:0] mA, mB, mRes;
  logic [OPW-1:0] mOp;
  logic           mResValid, mZero, mNeg;
  logic           mLoadPrev, mClearPrev;
  logic           mLive;
  logic           lEdge, cEdge;

  initial mLive = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mPhase = 0; mA = '0; mB = '0; mOp = '0; mRes = '0;
      mResValid = 1'b0; mZero = 1'b0; mNeg = 1'b0;
      mLoadPrev = 1'b1; mClearPrev = 1'b1;
      mLive = 1'b1;
    end else if (mLive) begin
      lEdge = loadBtn && !mLoadPrev;
      cEdge = clearBtn && !mClearPrev;
      mLoadPrev = loadBtn;
      mClearPrev = clearBtn;
      if (cEdge) begin
        mPhase = 0; mA = '0; mB = '0; mOp = '0; mRes = '0;
        mResValid = 1'b0; mZero = 1'b0; mNeg = 1'b0;
      end else if (mPhase == 0 && lEdge) begin
        mA = swData; mPhase = 1;
      end else if (mPhase == 1 && lEdge) begin
        mB = swData; mOp = swOp; mPhase = 2;
      end else if (mPhase == 2 && aluIf.alu_ready) begin
        mRes = aluIf.alu_result;
        mZero = (aluIf.alu_result == 0);
        mNeg = ($signed(aluIf.alu_result) < 0);
        mResValid = 1'b1; mPhase = 3;
      end else if (mPhase == 3 && lEdge) begin
        mA = swData; mResValid = 1'b0; mPhase = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (mLive) begin
      checkOutput("model state", stateQ, mPhase);
      checkOutput("model alu_a", aluIf.alu_a, mA);
      checkOutput("model alu_b", aluIf.alu_b, mB);
      checkOutput("model alu_op", aluIf.alu_op, mOp);
      checkOutput("model alu_valid", aluIf.alu_valid, (mPhase == 2) ? 1 : 0);
      checkOutput("model res_q", resQ, mRes);
      checkOutput("model res_valid", resValid, mResValid);
      checkOutput("model zero_flag", zeroFlag, mZero);
      checkOutput("model neg_flag", negFlag, mNeg);
    end
  end

  task automatic applyStimulus(input logic ld, input logic cl, input logic [WIDTH-1:0] d,
                               input logic [OPW-1:0] op, input logic rdy,
                               input logic [WIDTH-1:0] res);
    @(negedge clk);
    loadBtn = ld;
    clearBtn = cl;
    swData = d;
    swOp = op;
    aluIf.alu_ready = rdy;
    aluIf.alu_result = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    assertCount = 0;
    failCount = 0;
    reset = 1'b1;
    loadBtn = 1'b0;
    clearBtn = 1'b0;
    swData = '0;
    swOp = '0;
    aluIf.alu_ready = 1'b0;
    aluIf.alu_result = '0;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("reset state", stateQ, 0);
    checkOutput("reset alu_valid", aluIf.alu_valid, 0);
    checkOutput("reset res_q", resQ, 0);

    // Positive compare: 5 > 3
    applyStimulus(1, 0, 6'b000101, 3'd0, 0, 6'd0); tick();
    checkOutput("posA state", stateQ, 1);
    checkOutput("posA alu_a", aluIf.alu_a, 5);
    applyStimulus(0, 0, 6'b000101, 3'd0, 0, 6'd0); tick();
    applyStimulus(1, 0, 6'b000011, OP_GT, 1, 6'b000001); tick();
    checkOutput("pos alu_valid", aluIf.alu_valid, 1);
    checkOutput("pos alu_b", aluIf.alu_b, 3);
    checkOutput("pos alu_op", aluIf.alu_op, 5);
    applyStimulus(0, 0, 6'b000011, OP_GT, 1, 6'b000001); tick();
    checkOutput("pos res_q", resQ, 1);
    checkOutput("pos res_valid", resValid, 1);
    checkOutput("pos zero", zeroFlag, 0);
    checkOutput("pos neg", negFlag, 0);
    checkOutput("pos state", stateQ, 3);
    checkOutput("pos valid drop", aluIf.alu_valid, 0);

    // Negative operand: -5 > 2 is false
    applyStimulus(1, 0, 6'b111011, 3'd0, 0, 6'd0); tick();
    checkOutput("neg restart state", stateQ, 1);
    checkOutput("neg restart res_valid", resValid, 0);
    checkOutput("neg restart res_q held", resQ, 1);
    applyStimulus(0, 0, 6'b111011, 3'd0, 0, 6'd0); tick();
    applyStimulus(1, 0, 6'b000010, OP_GT, 1, 6'b000000); tick();
    applyStimulus(0, 0, 6'b000010, OP_GT, 1, 6'b000000); tick();
    checkOutput("gt false res_q", resQ, 0);
    checkOutput("gt false zero", zeroFlag, 1);
    checkOutput("gt false neg", negFlag, 0);

    // 2 - 9 = -7 = 111001
    applyStimulus(1, 0, 6'd2, 3'd0, 0, 6'd0); tick();
    applyStimulus(0, 0, 6'd2, 3'd0, 0, 6'd0); tick();
    applyStimulus(1, 0, 6'd9, OP_SUB, 1, 6'b111001); tick();
    applyStimulus(0, 0, 6'd9, OP_SUB, 1, 6'b111001); tick();
    checkOutput("sub res_q", resQ, 57);
    checkOutput("sub neg", negFlag, 1);
    checkOutput("sub zero", zeroFlag, 0);

    // Backpressure with toggling switches and stray load presses
    applyStimulus(1, 0, 6'd7, 3'd0, 0, 6'd0); tick();
    applyStimulus(0, 0, 6'd7, 3'd0, 0, 6'd0); tick();
    applyStimulus(1, 0, 6'd1, OP_ADD, 0, 6'd0); tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 0, 6'(i * 13 + 3), 3'(i + 2), 0, 6'd33); tick();
      checkOutput("bp alu_valid", aluIf.alu_valid, 1);
      checkOutput("bp alu_a", aluIf.alu_a, 7);
      checkOutput("bp alu_b", aluIf.alu_b, 1);
      checkOutput("bp alu_op", aluIf.alu_op, 0);
      checkOutput("bp res_valid", resValid, 0);
    end
    applyStimulus(0, 0, 6'd0, 3'd0, 1, 6'd8); tick();
    checkOutput("bp res_q", resQ, 8);
    checkOutput("bp state", stateQ, 3);
    applyStimulus(0, 0, 6'd0, 3'd0, 0, 6'd0); tick();

    // Clear in S_DONE, then held load button
    applyStimulus(0, 1, 6'd0, 3'd0, 0, 6'd0); tick();
    checkOutput("clear done res_valid", resValid, 0);
    checkOutput("clear done state", stateQ, 0);
    applyStimulus(0, 0, 6'd0, 3'd0, 0, 6'd0); tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 6'h15, 3'd0, 0, 6'd0); tick();
    end
    checkOutput("held state", stateQ, 1);
    checkOutput("held alu_a", aluIf.alu_a, 21);
    applyStimulus(0, 0, 6'h2A, 3'd0, 0, 6'd0); tick();
    checkOutput("held release state", stateQ, 1);

    // Load held through reset release
    @(negedge clk);
    reset = 1'b1;
    loadBtn = 1'b1;
    swData = 6'h1F;
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick(); tick(); tick();
    checkOutput("reset-held state", stateQ, 0);
    checkOutput("reset-held alu_a", aluIf.alu_a, 0);
    applyStimulus(0, 0, 6'd0, 3'd0, 0, 6'd0); tick();

    // Clear and load together in S_WAIT_B
    applyStimulus(1, 0, 6'd9, 3'd0, 0, 6'd0); tick();
    applyStimulus(0, 0, 6'd9, 3'd0, 0, 6'd0); tick();
    applyStimulus(1, 1, 6'h2A, OP_XOR, 0, 6'd0); tick();
    checkOutput("clr+ld state", stateQ, 0);
    checkOutput("clr+ld alu_a", aluIf.alu_a, 0);
    checkOutput("clr+ld alu_b", aluIf.alu_b, 0);
    checkOutput("clr+ld alu_op", aluIf.alu_op, 0);
    applyStimulus(0, 0, 6'd0, 3'd0, 0, 6'd0); tick();

    // Reset in S_ISSUE with ready high
    applyStimulus(1, 0, 6'd4, 3'd0, 0, 6'd0); tick();
    applyStimulus(0, 0, 6'd4, 3'd0, 0, 6'd0); tick();
    applyStimulus(1, 0, 6'd6, OP_AND, 0, 6'd0); tick();
    checkOutput("pre-reset state", stateQ, 2);
    applyStimulus(0, 0, 6'd6, OP_AND, 1, 6'h11);
    reset = 1'b1;
    tick();
    checkOutput("midreset state", stateQ, 0);
    checkOutput("midreset res_q", resQ, 0);
    checkOutput("midreset res_valid", resValid, 0);
    checkOutput("midreset alu_valid", aluIf.alu_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    aluIf.alu_ready = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
